vh_result_unpacker: RTL



---
 rtl/vh_result_pkg.sv | 19 +
 rtl/vh_sig_misr.sv | 17 +
 rtl/vh_result_unpacker.sv | 78 +++++++
 3 files changed

// File: rtl/vh_result_pkg.sv
// vh_result_pkg: shared constants, state encoding and field geometry for the result unpacker
package vh_result_pkg;
  localparam int VH_Y_W = 90;
  localparam int VH_NFIELD = 18;
  localparam logic [15:0] VH_SIG_POLY = 16'h1021;
  localparam logic [15:0] VH_SIG_INIT = 16'hFFFF;
  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} vh_unpk_state_t;
  function automatic int field_w(logic [4:0] k);
    return 4 + int'(k % 5'd3);
  endfunction
  function automatic int field_msb(logic [4:0] k);
    int j;
    j = int'(k % 5'd3);
    return 89 - 15 * int'(k / 5'd3) - (j == 0 ? 0 : j == 1 ? 4 : 9);
  endfunction
  function automatic logic field_signed(logic [4:0] k);
    return (k % 5'd6) >= 5'd3;
  endfunction
endpackage

// File: rtl/vh_sig_misr.sv
// vh_sig_misr: 16-bit CRC-style signature accumulator with clear and enable
module vh_sig_misr
  import vh_result_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [15:0] din,
  output logic [15:0] sig
);
  // clear wins over a same-cycle accumulate
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sig <= VH_SIG_INIT;
    else if (clr) sig <= VH_SIG_INIT;
    else if (en) sig <= {sig[14:0], 1'b0} ^ (sig[15] ? VH_SIG_POLY : 16'h0) ^ din;
endmodule

// File: rtl/vh_result_unpacker.sv
// vh_result_unpacker: splits the 90-bit packed result into 18 extended field beats; VH_SIGNATURE_EN adds sig/word_cnt
module vh_result_unpacker
  import vh_result_pkg::*;
#(
  parameter int OUT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [VH_Y_W-1:0] in_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [4:0]        out_idx,
`ifdef VH_SIGNATURE_EN
  input  logic              sig_clr,
  output logic [15:0]       sig,
  output logic [15:0]       word_cnt,
`endif
  output logic              out_last
);
  localparam logic S_IDLE = IDLE;
  localparam logic S_STREAM = STREAM;
  localparam logic [4:0] LAST_IDX = 5'(VH_NFIELD - 1);
  logic state;
  logic [4:0] idx;
  logic [VH_Y_W-1:0] hold;
  logic [VH_Y_W-1:0] sh;
  logic [5:0] top6;
  logic [OUT_W-1:0] mask;
  logic at_last, beat, take;
  assign at_last = idx == LAST_IDX;
  assign out_valid = state == S_STREAM;
  assign beat = out_valid & out_ready;
  assign in_ready = rst_n & ((state == S_IDLE) | (at_last & beat));
  assign take = in_valid & in_ready;
  assign out_idx = idx;
  assign out_last = at_last;
  // a new word restarts at field 0; the final beat either chains the next word or drops to idle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      idx <= '0;
    end else if (take) begin
      state <= S_STREAM;
      idx <= '0;
    end else if (beat) begin
      state <= at_last ? S_IDLE : S_STREAM;
      idx <= at_last ? '0 : idx + 5'd1;
    end
  // in_y is only looked at on an accepted handshake
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) hold <= '0;
    else if (take) hold <= in_y;
  // align the current field at bit 0, then mask or sign-fill above its width
  always_comb begin
    sh = hold >> (field_msb(idx) - field_w(idx) + 1);
    top6 = sh[5:0] >> (field_w(idx) - 1);
    mask = ~({OUT_W{1'b1}} << field_w(idx));
    out_data = (field_signed(idx) & top6[0]) ? (sh[OUT_W-1:0] | ~mask) : (sh[OUT_W-1:0] & mask);
  end
`ifdef VH_SIGNATURE_EN
  vh_sig_misr u_misr (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (sig_clr),
    .en   (beat),
    .din  (16'(out_data)),
    .sig  (sig)
  );
  // completed words, counted on the accepted last beat
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) word_cnt <= '0;
    else if (sig_clr) word_cnt <= '0;
    else if (beat & at_last) word_cnt <= word_cnt + 16'd1;
`endif
endmodule
